// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction prefetcher with a single outstanding memory request,
// a DEPTH-entry {pc, inst} FIFO and redirect flush that drains stale responses.
module inst_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
  state_t state_q, state_d;
  logic [31:0] fpc_q, fpc_d, addr_q, addr_d, tgt;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, count_pp;
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic push, pop;
  assign tgt = redirect_pc & ~32'h3;
  always_comb begin
    push     = (state_q == WAIT) && mem_ack && !redirect_valid;
    pop      = (count_q != '0) && inst_ready && !redirect_valid;
    count_pp = count_q + CW'(push) - CW'(pop);
    count_d  = redirect_valid ? '0 : count_pp;
    head_d   = redirect_valid ? tail_q : head_q + AW'(pop);
    tail_d   = tail_q + AW'(push);
    fpc_d    = redirect_valid ? tgt : fpc_q;
    addr_d   = addr_q;
    state_d  = state_q;
    case (state_q)
      IDLE: begin
        addr_d  = fpc_d;
        state_d = (redirect_valid || count_q != FULL) ? WAIT : IDLE;
      end
      WAIT: begin
        if (redirect_valid) begin
          addr_d  = mem_ack ? tgt : addr_q;
          state_d = mem_ack ? WAIT : DRAIN;
        end else if (mem_ack) begin
          fpc_d   = fpc_q + 32'd4;
          addr_d  = fpc_d;
          state_d = (count_pp != FULL) ? WAIT : IDLE;
        end
      end
      DRAIN: begin
        // the response in flight belongs to the abandoned stream; drop it and refetch
        addr_d  = mem_ack ? fpc_d : addr_q;
        state_d = mem_ack ? WAIT : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      fpc_q   <= RESET_PC;
      addr_q  <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      addr_q  <= addr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      pc_mem[tail_q]   <= addr_q;
      inst_mem[tail_q] <= mem_rdata;
    end
  end
  assign mem_req    = state_q != IDLE;
  assign mem_addr   = addr_q;
  assign inst_valid = count_q != '0;
  assign inst       = inst_mem[head_q];
  assign inst_pc    = pc_mem[head_q];
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed scenarios plus a randomized run checked against an
// occupancy/expected-PC model of the fetch stream.
module tb_inst_fetch_unit;
  localparam int DEPTH = 4;
  logic CLK = 0, RST = 1;
  logic mem_req, mem_ack = 0, redirect_valid = 0, inst_valid, inst_ready = 0;
  logic [31:0] mem_addr, mem_rdata, redirect_pc = 0, inst, inst_pc;
  logic req2, iv2;
  logic [31:0] addr2, rdata2, inst2, ipc2;
  int tests = 0, fails = 0;

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
  endfunction

  assign mem_rdata = f(mem_addr);
  assign rdata2    = f(addr2);

  inst_fetch_unit #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready));

  inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .CLK(CLK), .RST(RST), .mem_req(req2), .mem_addr(addr2), .mem_ack(req2),
    .mem_rdata(rdata2), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_valid(iv2), .inst(inst2), .inst_pc(ipc2), .inst_ready(1'b1));

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1; mem_ack = 0; inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
    tick; tick;
    RST = 0;
    tick;
  endtask

  task automatic test_reset;
    RST = 1; mem_ack = 1; inst_ready = 1;
    tick; tick;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_req got=%b exp=0", mem_req); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", inst_valid); end
    tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
    RST = 0; mem_ack = 0; inst_ready = 0;
    tick;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin fails++; $display("FAIL first_req got=%b/%h exp=1/0", mem_req, mem_addr); end
  endtask

  task automatic test_stream;
    do_reset;
    inst_ready = 1; mem_ack = 1;
    for (int i = 0; i < 5; i++) begin
      tests++; if (mem_req !== 1'b1 || mem_addr !== 32'(4 * i)) begin fails++; $display("FAIL stream_addr%0d got=%b/%h exp=1/%h", i, mem_req, mem_addr, 4 * i); end
      tests++; if (inst_valid !== (i > 0)) begin fails++; $display("FAIL stream_valid%0d got=%b exp=%b", i, inst_valid, i > 0); end
      if (i > 0) begin
        tests++; if (inst_pc !== 32'(4 * (i - 1)) || inst !== f(32'(4 * (i - 1)))) begin fails++; $display("FAIL stream_pc%0d got=%h/%h exp=%h", i, inst_pc, inst, 4 * (i - 1)); end
      end
      tick;
    end
    mem_ack = 0;
  endtask

  task automatic test_full;
    do_reset;
    mem_ack = 1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (mem_req !== 1'b1 || mem_addr !== 32'(4 * i)) begin fails++; $display("FAIL full_addr%0d got=%b/%h exp=1/%h", i, mem_req, mem_addr, 4 * i); end
      tick;
    end
    mem_ack = 0;
    for (int i = 0; i < 2; i++) begin
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL full_req%0d got=%b exp=0", i, mem_req); end
      tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin fails++; $display("FAIL full_head%0d got=%b/%h exp=1/0", i, inst_valid, inst_pc); end
      if (i == 0) tick;
    end
    inst_ready = 1;
    tick;
    inst_ready = 0;
    tests++; if (inst_pc !== 32'h4) begin fails++; $display("FAIL full_pop got=%h exp=4", inst_pc); end
    tick;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin fails++; $display("FAIL full_refill got=%b/%h exp=1/10", mem_req, mem_addr); end
  endtask

  task automatic test_redirect_wait;
    do_reset;
    inst_ready = 1; mem_ack = 1;
    tick; tick;
    mem_ack = 0;
    tests++; if (mem_addr !== 32'h8) begin fails++; $display("FAIL rw_addr8 got=%h exp=8", mem_addr); end
    redirect_valid = 1; redirect_pc = 32'h0000_0103;
    tick;
    redirect_valid = 0;
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rw_flush got=%b exp=0", inst_valid); end
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin fails++; $display("FAIL rw_hold got=%b/%h exp=1/8", mem_req, mem_addr); end
    tick;
    mem_ack = 1;
    tick;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || inst_valid !== 1'b0) begin fails++; $display("FAIL rw_refetch got=%b/%h/%b exp=1/100/0", mem_req, mem_addr, inst_valid); end
    tick;
    mem_ack = 0;
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== f(32'h100)) begin fails++; $display("FAIL rw_deliver got=%b/%h/%h exp=1/100/%h", inst_valid, inst_pc, inst, f(32'h100)); end
  endtask

  task automatic test_redirect_ack_pop;
    do_reset;
    inst_ready = 1; mem_ack = 1;
    tick;
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin fails++; $display("FAIL rap_head got=%b/%h exp=1/0", inst_valid, inst_pc); end
    redirect_valid = 1; redirect_pc = 32'h200;
    tick;
    redirect_valid = 0; mem_ack = 0;
    tests++; if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h200) begin fails++; $display("FAIL rap_next got=%b/%b/%h exp=0/1/200", inst_valid, mem_req, mem_addr); end
    tick;
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rap_drop got=%b exp=0", inst_valid); end
  endtask

  task automatic test_drain_reset;
    do_reset;
    redirect_valid = 1; redirect_pc = 32'h40;
    tick;
    redirect_valid = 0;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin fails++; $display("FAIL dr_drain got=%b/%h exp=1/0", mem_req, mem_addr); end
    RST = 1; mem_ack = 1;
    tick;
    RST = 0; mem_ack = 0;
    tests++; if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin fails++; $display("FAIL dr_reset got=%b/%b exp=0/0", mem_req, inst_valid); end
    tick;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin fails++; $display("FAIL dr_refetch got=%b/%h exp=1/0", mem_req, mem_addr); end
  endtask

  task automatic test_wrap;
    logic [31:0] exp [3];
    exp[0] = 32'hFFFF_FFF8; exp[1] = 32'hFFFF_FFFC; exp[2] = 32'h0;
    do_reset;
    tests++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFF8) begin fails++; $display("FAIL wrap_req got=%b/%h exp=1/fffffff8", req2, addr2); end
    for (int i = 0; i < 3; i++) begin
      tick;
      tests++; if (iv2 !== 1'b1 || ipc2 !== exp[i] || inst2 !== f(exp[i])) begin fails++; $display("FAIL wrap_pc%0d got=%b/%h exp=1/%h", i, iv2, ipc2, exp[i]); end
    end
  endtask

  task automatic test_random;
    int occ, stale, hold;
    logic [31:0] exp_pc, hold_addr;
    logic pop;
    do_reset;
    occ = 0; stale = 0; hold = 0; exp_pc = 32'h0; hold_addr = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      tests++; if (inst_valid !== (occ != 0)) begin fails++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, inst_valid, occ != 0); end
      if (occ != 0) begin
        tests++; if (inst_pc !== exp_pc || inst !== f(exp_pc)) begin fails++; $display("FAIL rnd_head n=%0d got=%h/%h exp=%h/%h", n, inst_pc, inst, exp_pc, f(exp_pc)); end
      end
      if (hold != 0) begin
        tests++; if (mem_req !== 1'b1 || mem_addr !== hold_addr) begin fails++; $display("FAIL rnd_stable n=%0d got=%b/%h exp=1/%h", n, mem_req, mem_addr, hold_addr); end
      end
      if (occ == DEPTH) begin
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rnd_fullreq n=%0d got=%b exp=0", n, mem_req); end
      end
      mem_ack = mem_req && ($urandom_range(0, 1) == 1);
      inst_ready = $urandom_range(0, 4) < 2;
      redirect_valid = $urandom_range(0, 15) == 0;
      redirect_pc = $urandom;
      pop = (occ != 0) && inst_ready;
      if (redirect_valid) begin
        occ = 0;
        exp_pc = redirect_pc & ~32'h3;
        stale = int'(mem_req && !mem_ack);
      end else begin
        occ = occ + int'(mem_ack && stale == 0) - int'(pop);
        if (mem_ack) stale = 0;
        if (pop) exp_pc = exp_pc + 32'd4;
      end
      hold = int'(mem_req && !mem_ack);
      hold_addr = mem_addr;
      tick;
    end
    mem_ack = 0; inst_ready = 0; redirect_valid = 0;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_full;
    test_redirect_wait;
    test_redirect_ack_pop;
    test_drain_reset;
    test_wrap;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
